// File: rtl/aes_key_sched_ctrl_if.sv
// rtl/aes_key_sched_ctrl_if.sv - key load and round-key read bundle for the AES-128 key-schedule controller
interface aes_key_sched_ctrl_if;
    logic         key_valid;
    logic [127:0] key;
    logic         key_ready;
    logic         busy;
    logic         keys_ready;
    logic         rk_req;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic [127:0] rk_out;
    logic         rk_err;

    modport master (
        output key_valid, key, rk_req, rk_idx,
        input  key_ready, busy, keys_ready, rk_valid, rk_out, rk_err
    );

    modport slave (
        input  key_valid, key, rk_req, rk_idx,
        output key_ready, busy, keys_ready, rk_valid, rk_out, rk_err
    );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - iterative AES-128 key expansion into an 11-entry round-key file with registered reads
module aes_key_sched_ctrl #(
    parameter int NR = 10
) (
    input logic                 clk,
    input logic                 rst_n,
    aes_key_sched_ctrl_if.slave bus
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           load, step;
    logic [127:0]   rk [0:NR];
    logic [127:0]   cur_rk, gen_rk;
    logic [31:0]    rot_w3, sub_t;
    logic           rk_valid_q, rk_err_q;
    logic [127:0]   rk_out_q;

    // Byte b sits at offset (255-b)*8 in the packed table; 255-b is simply ~b.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // The single shared generation step: rk[cnt] -> rk[cnt+1].
    always_comb begin
        cur_rk = rk[cnt_q];
        rot_w3 = {cur_rk[23:0], cur_rk[31:24]};
        sub_t  = {sbox(rot_w3[31:24]) ^ rcon(cnt_q), sbox(rot_w3[23:16]),
                  sbox(rot_w3[15:8]), sbox(rot_w3[7:0])};
        gen_rk[127:96] = cur_rk[127:96] ^ sub_t;
        gen_rk[95:64]  = gen_rk[127:96] ^ cur_rk[95:64];
        gen_rk[63:32]  = gen_rk[95:64]  ^ cur_rk[63:32];
        gen_rk[31:0]   = gen_rk[63:32]  ^ cur_rk[31:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE, READY: begin
                if (bus.key_valid) begin
                    load    = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                step  = 1'b1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(NR - 1)) begin
                    state_d = READY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i <= NR; i++) begin
                rk[i] <= '0;
            end
        end else if (load) begin
            rk[0] <= bus.key;
        end else if (step) begin
            rk[cnt_q + 4'd1] <= gen_rk;
        end
    end

    // Reads are judged on the pre-edge state, so a read alongside a reload sees the old schedule.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rk_valid_q <= 1'b0;
            rk_err_q   <= 1'b0;
            rk_out_q   <= '0;
        end else begin
            rk_valid_q <= bus.rk_req;
            if (bus.rk_req) begin
                if (state_q == READY && bus.rk_idx <= 4'(NR)) begin
                    rk_out_q <= rk[bus.rk_idx];
                    rk_err_q <= 1'b0;
                end else begin
                    rk_out_q <= '0;
                    rk_err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.key_ready  = (state_q != EXPAND);
    assign bus.busy       = (state_q == EXPAND);
    assign bus.keys_ready = (state_q == READY);
    assign bus.rk_valid   = rk_valid_q;
    assign bus.rk_err     = rk_err_q;
    assign bus.rk_out     = rk_out_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb/tb_aes_key_sched_ctrl.sv - directed known-answer bench for aes_key_sched_ctrl
module tb_aes_key_sched_ctrl;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fails = 0;

    aes_key_sched_ctrl_if bus ();

    aes_key_sched_ctrl #(.NR(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " key_ready"}, 128'(bus.key_ready), 128'd1);
        chk({tag, " busy"}, 128'(bus.busy), 128'd0);
        chk({tag, " keys_ready"}, 128'(bus.keys_ready), 128'd0);
        chk({tag, " rk_valid"}, 128'(bus.rk_valid), 128'd0);
        chk({tag, " rk_err"}, 128'(bus.rk_err), 128'd0);
        chk({tag, " rk_out"}, bus.rk_out, 128'd0);
    endtask

    task automatic read_rk(input string tag, input logic [3:0] idx,
                           input logic exp_err, input logic [127:0] exp_out);
        bus.rk_req = 1'b1;
        bus.rk_idx = idx;
        tick();
        bus.rk_req = 1'b0;
        chk({tag, " rk_valid"}, 128'(bus.rk_valid), 128'd1);
        chk({tag, " rk_err"}, 128'(bus.rk_err), 128'(exp_err));
        chk({tag, " rk_out"}, bus.rk_out, exp_out);
    endtask

    // Load a key and verify the busy/keys_ready timeline E0..E10.
    task automatic load_key(input string tag, input logic [127:0] k);
        bus.key_valid = 1'b1;
        bus.key       = k;
        tick();
        bus.key_valid = 1'b0;
        chk({tag, " busy@E0"}, 128'(bus.busy), 128'd1);
        chk({tag, " key_ready@E0"}, 128'(bus.key_ready), 128'd0);
        repeat (9) tick();
        chk({tag, " keys_ready@E9"}, 128'(bus.keys_ready), 128'd0);
        tick();
        chk({tag, " keys_ready@E10"}, 128'(bus.keys_ready), 128'd1);
        chk({tag, " key_ready@E10"}, 128'(bus.key_ready), 128'd1);
    endtask

    initial begin
        bus.key_valid = 1'b0;
        bus.key       = '0;
        bus.rk_req    = 1'b0;
        bus.rk_idx    = 4'd0;
        @(negedge clk);
        repeat (2) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        load_key("fips", FIPS_KEY);
        read_rk("fips idx1", 4'd1, 1'b0, FIPS_RK1);
        read_rk("fips idx10", 4'd10, 1'b0, FIPS_RK10);
        read_rk("fips idx0", 4'd0, 1'b0, FIPS_KEY);
        read_rk("idx11", 4'd11, 1'b1, 128'd0);
        read_rk("idx15", 4'd15, 1'b1, 128'd0);

        // Reload with the zero key while reading rk[10] of the old schedule.
        bus.key_valid = 1'b1;
        bus.key       = '0;
        bus.rk_req    = 1'b1;
        bus.rk_idx    = 4'd10;
        tick();
        bus.key_valid = 1'b0;
        bus.rk_req    = 1'b0;
        chk("reload read rk_valid", 128'(bus.rk_valid), 128'd1);
        chk("reload read rk_err", 128'(bus.rk_err), 128'd0);
        chk("reload read rk_out", bus.rk_out, FIPS_RK10);
        chk("reload keys_ready drop", 128'(bus.keys_ready), 128'd0);
        read_rk("read in expand", 4'd1, 1'b1, 128'd0);
        bus.key_valid = 1'b1;
        bus.key       = FIPS_KEY;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("key_ready held E%0d", i + 2), 128'(bus.key_ready), 128'd0);
        end
        bus.key_valid = 1'b0;
        repeat (2) tick();
        chk("zero keys_ready@E9", 128'(bus.keys_ready), 128'd0);
        tick();
        chk("zero keys_ready@E10", 128'(bus.keys_ready), 128'd1);
        read_rk("zero idx1", 4'd1, 1'b0, ZERO_RK1);
        read_rk("zero idx10", 4'd10, 1'b0, ZERO_RK10);

        // Back-to-back burst over all 11 entries.
        begin
            int pulses = 0;
            bus.rk_req = 1'b1;
            for (int i = 0; i <= 10; i++) begin
                bus.rk_idx = 4'(i);
                tick();
                if (bus.rk_valid === 1'b1 && bus.rk_err === 1'b0) pulses++;
                if (i == 0) chk("burst idx0", bus.rk_out, 128'd0);
                if (i == 1) chk("burst idx1", bus.rk_out, ZERO_RK1);
                if (i == 10) chk("burst idx10", bus.rk_out, ZERO_RK10);
            end
            bus.rk_req = 1'b0;
            chk("burst pulses", 128'(pulses), 128'd11);
            tick();
            chk("burst end rk_valid", 128'(bus.rk_valid), 128'd0);
        end

        // Reset at cnt == 5 together with a pending read request.
        bus.key_valid = 1'b1;
        bus.key       = FIPS_KEY;
        tick();
        bus.key_valid = 1'b0;
        repeat (5) tick();
        rst_n      = 1'b0;
        bus.rk_req = 1'b1;
        bus.rk_idx = 4'd3;
        tick();
        rst_n      = 1'b1;
        bus.rk_req = 1'b0;
        check_reset_outputs("mid reset");
        load_key("fips again", FIPS_KEY);
        read_rk("again idx1", 4'd1, 1'b0, FIPS_RK1);
        read_rk("again idx10", 4'd10, 1'b0, FIPS_RK10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
